// File: rtl/mines_pkg.sv
// mines_pkg: shared definitions for the minesweeper core.
//   - grid defaults (tiles per side, tile count, tile index width)
//   - LFSR feedback mask, default seed and a single-step helper
//   - mine placer state encoding
package mines_pkg;

    localparam int          MP_GRID_SIZE     = 5;
    localparam int          MP_TOTAL_SQUARES = MP_GRID_SIZE * MP_GRID_SIZE;
    localparam int          MP_INDEX_WIDTH   = $clog2(MP_TOTAL_SQUARES);
    localparam logic [15:0] MP_LFSR_MASK     = 16'hB400;
    localparam logic [15:0] MP_SEED          = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLACE = 2'd1,
        ST_DONE  = 2'd2
    } placer_state_e;

    // Galois step, shift right: x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? MP_LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/mine_lfsr.sv
// mine_lfsr: free-running 16-bit Galois LFSR, advances every clock out of
// reset. Shared randomness source for the game.
//   clk : clock
//   rst : asynchronous active-low reset, loads SEED
//   q   : current LFSR state
module mine_lfsr
    import mines_pkg::*;
#(
    parameter logic [15:0] SEED = MP_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_step(lfsr_q);
    end

    assign q = lfsr_q;

endmodule

// File: rtl/mine_placer.sv
// mine_placer: places NUM_MINES mines at distinct pseudo-random tiles,
// never on safe_index, then holds the map and pulses adj_start.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   start      : new placement request (honoured in IDLE / DONE only)
//   safe_index : tile kept mine-free, sampled with start
//   mine_map   : bit i set = mine on tile i (row-major)
//   busy       : placement in progress
//   done       : map final and stable
//   adj_start  : one-cycle kick to the adjacency engine
module mine_placer
    import mines_pkg::*;
#(
    parameter int          GRID_SIZE     = MP_GRID_SIZE,
    parameter int          TOTAL_SQUARES = GRID_SIZE * GRID_SIZE,
    parameter int          INDEX_WIDTH   = $clog2(TOTAL_SQUARES),
    parameter int          NUM_MINES     = 5,
    parameter logic [15:0] SEED          = MP_SEED
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [INDEX_WIDTH-1:0]   safe_index,
    output logic [TOTAL_SQUARES-1:0] mine_map,
    output logic                     busy,
    output logic                     done,
    output logic                     adj_start
);

    if (NUM_MINES < 1 || NUM_MINES > TOTAL_SQUARES - 1) begin : g_bad_mines
        $error("mine_placer: NUM_MINES out of range 1..TOTAL_SQUARES-1");
    end
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("mine_placer: SEED must be nonzero");
    end

    localparam int                   CW    = $clog2(NUM_MINES + 1);
    localparam logic [CW-1:0]        NM_W  = CW'(NUM_MINES);
    localparam logic [INDEX_WIDTH:0] TOT_W = (INDEX_WIDTH + 1)'(TOTAL_SQUARES);

    placer_state_e              state_q, state_d;
    logic [TOTAL_SQUARES-1:0]   map_q, map_d;
    logic [CW-1:0]              count_q, count_d;
    logic [INDEX_WIDTH-1:0]     safe_q, safe_d;
    logic                       adj_q, adj_d;

    logic [15:0]                lfsr;
    logic [INDEX_WIDTH-1:0]     cand;
    logic [2**INDEX_WIDTH-1:0]  map_ext;
    logic                       accept;
    logic                       unused_lfsr;

    mine_lfsr #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign cand        = lfsr[INDEX_WIDTH-1:0];
    assign unused_lfsr = ^lfsr[15:INDEX_WIDTH];

    // Zero-extended map so every candidate index is in range; tiles past
    // the board are also filtered by the range check.
    assign map_ext = (2**INDEX_WIDTH)'(map_q);

    // A safe_q beyond the board never matches an in-range candidate, so an
    // out-of-range safe_index excludes nothing.
    assign accept = ({1'b0, cand} < TOT_W) && (cand != safe_q) && !map_ext[cand];

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        count_d = count_q;
        safe_d  = safe_q;
        adj_d   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    safe_d  = safe_index;
                    map_d   = '0;
                    count_d = '0;
                    state_d = ST_PLACE;
                end
            end
            ST_PLACE: begin
                if (accept) begin
                    map_d[cand] = 1'b1;
                    count_d     = count_q + CW'(1);
                    if (count_d == NM_W) begin
                        state_d = ST_DONE;
                        adj_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            map_q   <= '0;
            count_q <= '0;
            safe_q  <= '0;
            adj_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            count_q <= count_d;
            safe_q  <= safe_d;
            adj_q   <= adj_d;
        end
    end

    assign mine_map  = map_q;
    assign busy      = (state_q == ST_PLACE);
    assign done      = (state_q == ST_DONE);
    assign adj_start = adj_q;

endmodule

// File: doc/mine_placer.md
# mine_placer

Generates the per-game mine map for the minesweeper core. On `start` it places exactly `NUM_MINES` mines at pseudo-random distinct tiles, never on the player's first-clicked tile. It holds the resulting `mine_map` stable and pulses `adj_start` so the adjacency-count FSM, which reads `mine_map`, begins its scan. It is the producer of the `mine_map` / start interface the adjacency engine consumes.

## Interface
- `GRID_SIZE`, default 5: tiles per row/column.
- `TOTAL_SQUARES`, default `GRID_SIZE*GRID_SIZE`: tile count.
- `INDEX_WIDTH`, default `$clog2(TOTAL_SQUARES)`: tile index width.
- `NUM_MINES`, default 5: mines per game; legal range is 1..`TOTAL_SQUARES-1`; any other value is an elaboration error.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

- `clk` input 1: clock.
- `rst` input 1: reset; asynchronous, active-low.
- `start` input 1: request a new placement; sampled only in IDLE or DONE.
- `safe_index` input `INDEX_WIDTH`: tile that must stay mine-free; sampled with `start`.
- `mine_map` output `TOTAL_SQUARES`: bit i = 1 means a mine at tile i (row-major).
- `busy` output 1: high while in PLACE.
- `done` output 1: high while in DONE; `mine_map` is final.
- `adj_start` output 1: one-cycle pulse to the adjacency engine.

## Operation
- **LFSR:** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), shift right. It advances every clock from reset regardless of state, so player timing supplies entropy.
- **Candidate:** `cand = lfsr[INDEX_WIDTH-1:0]`.
- **States:** IDLE, PLACE, DONE.
- **IDLE:** on `start`:
  - latch `safe_index` into `safe_q`;
  - clear `mine_map` and `count`;
  - go to PLACE.
- **PLACE:** every cycle, accept `cand` iff all of the following hold:
  - `cand < TOTAL_SQUARES`;
  - `cand != safe_q`;
  - `mine_map[cand] == 0`.
- **On accept:** set `mine_map[cand]` and increment `count`. If the new count equals `NUM_MINES`, go to DONE, set `done`, set `adj_start`.
- **On reject:** no change; retry on the next cycle with the new LFSR value.
- **DONE:** hold `mine_map` and `done`. On `start`, behave as IDLE does: relatch `safe_index`, clear map, clear `done`, go to PLACE.
- **`start` in PLACE:** ignored, with no effect on `safe_q` or the map.
- **`safe_index >= TOTAL_SQUARES`:** no tile is excluded; all tiles are eligible.
- **Termination:** the maximal-length LFSR cycles through every low-bit pattern, so PLACE always terminates. Worst case is bounded by `NUM_MINES` × 65535 cycles.
- **`count` width:** `$clog2(NUM_MINES+1)`; it never exceeds `NUM_MINES`.

## Timing
- **Reset values:**
  - `mine_map` = 0, `busy` = 0, `done` = 0, `adj_start` = 0;
  - state = IDLE, `lfsr` = `SEED`, `count` = 0.
- **Reset mid-operation:** reset applies asynchronously in any state; there is no partial-map retention.
- **Start edge (E0):** `start` is sampled at rising edge E0. After E0: `busy` = 1, `done` = 0, `mine_map` = 0.
- **Placement rate:** at most one mine per cycle. Best case is edges E1..E_N for N = `NUM_MINES`.
- **Final accept edge:** `busy` 1→0, `done` 0→1, `adj_start` 0→1, and the final `mine_map` bit are all visible after the same edge.
- **`adj_start`:** high for exactly one cycle, cleared on the next edge.
- **Stability guarantee:** `mine_map` does not change while `done` = 1. Consumers may sample it at any cycle after `adj_start`.
- **Restart from DONE:** `done` falls on the edge that samples `start`.

## Structure
- **Shared package `mines_pkg`:**
  - grid defaults (`GRID_SIZE`, `TOTAL_SQUARES`, `INDEX_WIDTH`);
  - LFSR mask 16'hB400 and default `SEED`;
  - the state encoding (IDLE=0, PLACE=1, DONE=2).
- **Sub-module `mine_lfsr`:**
  - ports `clk`, `rst`, 16-bit `q`;
  - parameter `SEED`;
  - free-running; reused by any later random features.
- **Top level:** FSM, accept logic, `count`, `safe_q`, and the map register.

## Test plan
1. **Reset:** hold `rst`=0 for 3 cycles → all outputs 0; `mine_lfsr.q` = 16'hACE1 on release.
2. **Default placement:** defaults, `start` pulse with `safe_index`=12 → within bound:
   - `done`=1, `mine_map` popcount = 5, bit 12 = 0;
   - `adj_start` high exactly one cycle, coincident with `done` rising;
   - map equals the bench's bit-exact LFSR model.
3. **Full board:** `NUM_MINES`=24, `safe_index`=0 → `mine_map` = 25'h1FFFFFE.
4. **`start` during PLACE:** pulse `start` with `safe_index`=7 while `busy`=1 → ignored; final map matches the model run with the original `safe_index`.
5. **Restart from DONE:** `start` with `safe_index`=3 → `done` falls next edge, map clears, new map has bit 3 = 0 and popcount 5, and exactly one new `adj_start` pulse.
6. **Mid-placement reset:** `rst`=0 mid-PLACE → `busy`/`mine_map`/`count` clear immediately (async); after release, `start` produces the same map as a fresh run with identical timing.
